poly_tone_mixer: RTL and testbench
==================================

# poly_tone_mixer

Parametrised polyphonic square-wave tone generator and mixer. It drives the audio controller's output FIFO interface directly.
- Each of NUM_VOICES voices has a free-running half-period counter, loaded from a per-voice period table.
- The octave is shifted at run time by debounce-free, synchronised up/down edges.
- Key-gated voices are summed with signed saturation and pushed to both channels whenever the controller allows a write.

## Interface
- NUM_VOICES, 12, number of voices/keys (1..16)
- CNT_W, 20, counter width; each table entry must fit in CNT_W bits
- PERIODS, {191109,180388,170265,160705,151685,143172,135139,127551,120395,113636,107259,101239} (voice 0 = C), packed NUM_VOICES*CNT_W vector of octave-0 half periods in clock cycles; voice i at bits [i*CNT_W +: CNT_W]
- AMP, 100000000, per-voice amplitude magnitude
- OUT_W, 32, sample width, two's complement
- OCT_W, 2, octave register width
- OCT_MAX, 3, highest octave index
- OCT_RESET, 0, octave after reset
- CLOCK_50  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- keys  in  NUM_VOICES  async key levels; 1 = voice sounding
- oct_up  in  1  async level; each rising edge raises the octave
- oct_down  in  1  async level; each rising edge lowers the octave
- audio_out_allowed  in  1  controller FIFO has room
- write_audio_out  out  1  FIFO write strobe
- left_channel_audio_out  out  OUT_W  mixed sample
- right_channel_audio_out  out  OUT_W  identical to left
- octave  out  OCT_W  current octave index

## Operation
- **Synchronisers.** keys, oct_up and oct_down each pass through 2 flops (s1, s2). oct_up and oct_down also have a third flop s3.
- **Octave edges.** up_edge = s2 & ~s3; dn_edge likewise.
  - up_edge alone: octave increments, saturating at OCT_MAX.
  - dn_edge alone: octave decrements, saturating at 0.
  - Both edges in the same cycle: no change.
- **Half period.** half_i = PERIODS[i] >> octave. If the result is < 1, use 1.
- **Voice i.** Counter cnt_i and phase bit ph_i.
  - When cnt_i == half_i-1: ph_i toggles and cnt_i returns to 0.
  - Otherwise cnt_i increments.
  - Resulting square-wave period is 2*half_i cycles.
- **Octave change.** In the cycle the octave register changes, all cnt_i clear to 0 and ph_i is held.
  - This guarantees no counter is ever above its new terminal count.
- **Key gating.** Counters run regardless of keys. A voice contributes +AMP if ph_i=1, -AMP if ph_i=0, and 0 if its synchronised key is 0.
- **Mixing.**
  - Contributions are summed at width OUT_W+5 bits (signed), then saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - The result is registered into mix_q every cycle.
  - With the defaults the sum never saturates (max 1.2e9).
- **Output.**
  - left_channel_audio_out = right_channel_audio_out = mix_q.
  - write_audio_out = audio_out_allowed & ~reset, combinational. This matches the controller's same-cycle write rule: a write is accepted only on an edge where allowed=1.
  - When allowed=0, nothing is written; mix_q keeps tracking.

## Timing
- **Reset values.** All outputs, cnt_i, mix_q and synchroniser flops = 0; ph_i = 1; octave = OCT_RESET; write_audio_out = 0 while reset is high.
- **Reset mid-operation.** On the next edge, everything returns to the reset values above. There is no partial state.
- **Key latency.** A key first sampled high at edge k gives a non-zero output after edge k+2. Release follows the same latency.
- **Octave latency.** oct_up first sampled high at edge k updates octave, and clears the counters, at edge k+2.
  - Holding the input high produces exactly one step. A new step needs a low sample followed by a high sample.
- **Phase to output.** A phase toggle at edge t appears on the output after edge t+1.
- **Handshake.** Throughput is one sample per cycle while audio_out_allowed=1. A deasserted allowed stalls nothing internally.

## Test plan
- **Reset values.** Hold reset for 3 cycles with keys=all 1s. Required: outputs 0, octave 0, write_audio_out 0. After release and once the keys are synchronised, output = 12*AMP = 1,200,000,000 (all ph=1).
- **Single voice.** keys=voice 9 only (A), octave 0. Required: output alternates +100000000 / -100000000 with a half period of exactly 113636 cycles. Check 4 consecutive transitions.
- **Octave up and saturation.** Pulse oct_up high for 10 cycles, twice. Required: octave 0→1→2, and voice 9's half period becomes 28409. Pulse 3 more times: octave stops at 3, half period 14204. Pulse oct_down 5 times: octave stops at 0.
- **Simultaneous edges.** oct_up and oct_down rise on the same cycle. Required: octave unchanged and counters not cleared.
- **Saturation.** Build with AMP=2^30.
  - Voices 0-2 keyed while all phases = 1: output 0x7FFFFFFF.
  - Force all three phases to 0: output 0x80000000.
- **Handshake and mid-run reset.**
  - With audio_out_allowed toggling 1,0,0,1: write_audio_out follows the same pattern and the data equals mix_q on write cycles.
  - Assert reset mid-half-period: on the next edge all counters and outputs are at their reset values, and the phase restarts at +AMP.

Source files
------------

// File: rtl/poly_tone_mixer.sv
// poly_tone_mixer: polyphonic square-wave tone generator and saturating mixer feeding the audio controller FIFO.
// Latency: key/octave inputs -> 2 synchroniser flops; mix_q is registered one cycle after a phase toggle.
// Backpressure: audio_out_allowed only gates the write strobe; voices and mix_q keep running while it is low.
//
// Ports:
//   CLOCK_50                  system clock, all logic on its rising edge
//   reset                     synchronous, active-high
//   keys[NUM_VOICES]          async key levels, 1 = voice sounding
//   oct_up / oct_down         async levels; each rising edge steps the octave up / down
//   audio_out_allowed         controller FIFO has room
//   write_audio_out           FIFO write strobe (combinational from allowed)
//   left/right_channel_audio_out  mixed sample, both channels identical
//   octave                    current octave index
module poly_tone_mixer #(
  parameter int                          NUM_VOICES = 12,
  parameter int                          CNT_W      = 20,
  // Voice 0 (C) sits in the least significant CNT_W bits.
  parameter logic [NUM_VOICES*CNT_W-1:0] PERIODS    = {20'd101239, 20'd107259, 20'd113636, 20'd120395,
                                                       20'd127551, 20'd135139, 20'd143172, 20'd151685,
                                                       20'd160705, 20'd170265, 20'd180388, 20'd191109},
  parameter longint                      AMP        = 100000000,
  parameter int                          OUT_W      = 32,
  parameter int                          OCT_W      = 2,
  parameter int                          OCT_MAX    = 3,
  parameter int                          OCT_RESET  = 0
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [NUM_VOICES-1:0] keys,
  input  logic                  oct_up,
  input  logic                  oct_down,
  input  logic                  audio_out_allowed,
  output logic                  write_audio_out,
  output logic [OUT_W-1:0]      left_channel_audio_out,
  output logic [OUT_W-1:0]      right_channel_audio_out,
  output logic [OCT_W-1:0]      octave
);

  // Five guard bits cover the sum of up to 16 full-scale voices.
  localparam int SUM_W = OUT_W + 5;

  localparam logic signed [SUM_W-1:0] AMP_S   = SUM_W'(AMP);
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  logic [NUM_VOICES-1:0] keys_s1, keys_s2;
  logic                  up_s1, up_s2, up_s3;
  logic                  dn_s1, dn_s2, dn_s3;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      keys_s1 <= '0;
      keys_s2 <= '0;
      up_s1   <= 1'b0;
      up_s2   <= 1'b0;
      up_s3   <= 1'b0;
      dn_s1   <= 1'b0;
      dn_s2   <= 1'b0;
      dn_s3   <= 1'b0;
    end else begin
      keys_s1 <= keys;
      keys_s2 <= keys_s1;
      up_s1   <= oct_up;
      up_s2   <= up_s1;
      up_s3   <= up_s2;
      dn_s1   <= oct_down;
      dn_s2   <= dn_s1;
      dn_s3   <= dn_s2;
    end
  end

  // ---------------------------------------------------------------------------
  // Octave register
  // ---------------------------------------------------------------------------
  logic             up_edge, dn_edge;
  logic [OCT_W-1:0] octave_q, octave_nxt;
  logic             oct_change;

  assign up_edge = up_s2 & ~up_s3;
  assign dn_edge = dn_s2 & ~dn_s3;

  // Opposing edges in the same cycle cancel out.
  always_comb begin
    octave_nxt = octave_q;
    if (up_edge && !dn_edge) begin
      if (octave_q < OCT_W'(OCT_MAX)) octave_nxt = octave_q + OCT_W'(1);
    end else if (dn_edge && !up_edge) begin
      if (octave_q != '0) octave_nxt = octave_q - OCT_W'(1);
    end
  end

  assign oct_change = (octave_nxt != octave_q);

  always_ff @(posedge CLOCK_50) begin
    if (reset) octave_q <= OCT_W'(OCT_RESET);
    else       octave_q <= octave_nxt;
  end

  // ---------------------------------------------------------------------------
  // Voices: half-period counter and phase bit per voice
  // ---------------------------------------------------------------------------
  logic signed [SUM_W-1:0] contrib [NUM_VOICES];

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] shifted;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt;
    logic             ph;

    assign period  = PERIODS[i*CNT_W +: CNT_W];
    assign shifted = period >> octave_q;
    // High octaves can shift short periods down to zero; one cycle is the floor.
    assign half    = (shifted == '0) ? CNT_W'(1) : shifted;

    // An octave change clears the counter so it can never sit above the
    // (smaller) new terminal count; the phase is kept so the tone is continuous.
    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        cnt <= '0;
        ph  <= 1'b1;
      end else if (oct_change) begin
        cnt <= '0;
      end else if (cnt == half - CNT_W'(1)) begin
        cnt <= '0;
        ph  <= ~ph;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign contrib[i] = !keys_s2[i] ? '0 : (ph ? AMP_S : -AMP_S);
  end

  // ---------------------------------------------------------------------------
  // Mixer with signed saturation
  // ---------------------------------------------------------------------------
  logic signed [SUM_W-1:0] sum;
  logic        [OUT_W-1:0] sat;
  logic        [OUT_W-1:0] mix_q;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      sum = sum + contrib[i];
    end
  end

  always_comb begin
    sat = sum[OUT_W-1:0];
    if (sum > SAT_MAX)      sat = {1'b0, {(OUT_W-1){1'b1}}};
    else if (sum < SAT_MIN) sat = {1'b1, {(OUT_W-1){1'b0}}};
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) mix_q <= '0;
    else       mix_q <= sat;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The controller accepts a write on any edge where allowed is high, so the
  // strobe follows allowed in the same cycle; only reset suppresses it.
  assign write_audio_out         = audio_out_allowed & ~reset;
  assign left_channel_audio_out  = mix_q;
  assign right_channel_audio_out = mix_q;
  assign octave                  = octave_q;

endmodule

// File: tb/tb_poly_tone_mixer.sv
// Directed bench for poly_tone_mixer.
// Main instance uses a table scaled down by 1000 (voice 9 half period 113) to keep runs short;
// a second 3-voice instance with AMP = 2^30 exercises mixer saturation.
module tb_poly_tone_mixer;

  localparam logic [239:0] TB_PERIODS = {20'd101, 20'd107, 20'd113, 20'd120, 20'd127, 20'd135,
                                         20'd143, 20'd151, 20'd160, 20'd170, 20'd180, 20'd191};
  localparam logic [31:0] AMP_P  = 32'd100000000;
  localparam logic [31:0] AMP_N  = 32'hFA0A_1F00;   // -100000000
  localparam logic [31:0] ALL_ON = 32'd1200000000;  // 12 * AMP, all phases high

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [11:0] keys;
  logic        oct_up, oct_down, audio_out_allowed;
  logic        write_audio_out;
  logic [31:0] left, right;
  logic [1:0]  octave;

  logic        s_reset;
  logic [2:0]  s_keys;
  logic        s_up, s_dn, s_allowed;
  logic        s_write;
  logic [31:0] s_left, s_right;
  logic [1:0]  s_octave;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  poly_tone_mixer #(.NUM_VOICES(12), .CNT_W(20), .PERIODS(TB_PERIODS), .AMP(100000000)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .keys(keys), .oct_up(oct_up), .oct_down(oct_down),
    .audio_out_allowed(audio_out_allowed), .write_audio_out(write_audio_out),
    .left_channel_audio_out(left), .right_channel_audio_out(right), .octave(octave));

  poly_tone_mixer #(.NUM_VOICES(3), .CNT_W(20), .PERIODS({20'd50, 20'd50, 20'd50}),
                    .AMP(64'd1073741824)) dut_sat (
    .CLOCK_50(CLOCK_50), .reset(s_reset), .keys(s_keys), .oct_up(s_up), .oct_down(s_dn),
    .audio_out_allowed(s_allowed), .write_audio_out(s_write),
    .left_channel_audio_out(s_left), .right_channel_audio_out(s_right), .octave(s_octave));

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  // Waits for the next output change; a timeout counts as a miscompare.
  task automatic wait_transition(input string name);
    logic [31:0] prev;
    int          n;
    prev = left;
    n    = 0;
    while (left == prev && n < 400) begin
      tick(1);
      n++;
    end
    if (left == prev) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no output transition within 400 cycles, output stuck at %0d", name, $signed(left));
    end
  endtask

  // Counts cycles from a just-observed transition to the next one, optionally
  // pulsing oct_up / oct_down (10 cycles) starting at the given cycle offsets.
  task automatic run_interval(input int up_at, input int dn_at, output int n);
    logic [31:0] prev;
    prev = left;
    n    = 0;
    do begin
      tick(1);
      n++;
      if (n == up_at)      oct_up   = 1'b1;
      if (n == up_at + 10) oct_up   = 1'b0;
      if (n == dn_at)      oct_down = 1'b1;
      if (n == dn_at + 10) oct_down = 1'b0;
    end while (left == prev && n < 600);
    oct_up   = 1'b0;
    oct_down = 1'b0;
  endtask

  // One 10-cycle pulse; the octave must move exactly 3 edges after driving it.
  task automatic pulse(input bit up, input logic [1:0] exp_oct);
    logic [1:0] old;
    old = octave;
    if (up) oct_up = 1'b1; else oct_down = 1'b1;
    tick(2);
    vectors++;
    if (octave !== old) begin
      miscompares++;
      $display("FAIL pulse_early: octave=%0d, should still be %0d", octave, old);
    end
    tick(1);
    vectors++;
    if (octave !== exp_oct) begin
      miscompares++;
      $display("FAIL pulse_step: octave=%0d, expected %0d", octave, exp_oct);
    end
    tick(7);
    oct_up   = 1'b0;
    oct_down = 1'b0;
    tick(10);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    keys  = 12'hFFF;
    audio_out_allowed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      vectors++;
      if (left !== 32'd0 || right !== 32'd0 || octave !== 2'd0 || write_audio_out !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state: left=%0d right=%0d octave=%0d write=%0b, expected 0/0/0/0",
                 left, right, octave, write_audio_out);
      end
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (write_audio_out !== 1'b1) begin
      miscompares++;
      $display("FAIL write_after_reset: write=%0b, expected 1", write_audio_out);
    end
    tick(2);
    vectors++;
    if (left !== 32'd0) begin
      miscompares++;
      $display("FAIL key_latency: output=%0d before keys synchronised, expected 0", left);
    end
    tick(1);
    vectors++;
    if (left !== ALL_ON) begin
      miscompares++;
      $display("FAIL all_keys: output=%0d, expected %0d", left, ALL_ON);
    end
  endtask

  task automatic test_single_voice;
    logic [31:0] prev;
    int          n;
    keys = 12'h200;
    tick(3);
    vectors++;
    if (left !== AMP_P && left !== AMP_N) begin
      miscompares++;
      $display("FAIL single_level: output=%0d, expected +/-100000000", $signed(left));
    end
    wait_transition("single_first");
    for (int t = 0; t < 4; t++) begin
      prev = left;
      run_interval(-100, -100, n);
      vectors++;
      if (n !== 113 || left !== (32'd0 - prev)) begin
        miscompares++;
        $display("FAIL single_half: half=%0d value=%0d, expected 113 and %0d",
                 n, $signed(left), -$signed(prev));
      end
    end
  endtask

  task automatic test_octave_up;
    int n;
    wait_transition("oct_sync");
    // Octave steps 22 cycles after the transition and clears the counters: 22 + 56 + 1.
    run_interval(19, -100, n);
    vectors++;
    if (n !== 79 || octave !== 2'd1) begin
      miscompares++;
      $display("FAIL oct_clear: interval=%0d octave=%0d, expected 79 and 1", n, octave);
    end
    tick(15);
    pulse(1'b1, 2'd2);
    wait_transition("oct2_sync");
    for (int t = 0; t < 2; t++) begin
      run_interval(-100, -100, n);
      vectors++;
      if (n !== 28) begin
        miscompares++;
        $display("FAIL oct2_half: half=%0d, expected 28", n);
      end
    end
    pulse(1'b1, 2'd3);
    pulse(1'b1, 2'd3);
    pulse(1'b1, 2'd3);
    wait_transition("oct3_sync");
    run_interval(-100, -100, n);
    vectors++;
    if (n !== 14) begin
      miscompares++;
      $display("FAIL oct3_half: half=%0d, expected 14", n);
    end
    pulse(1'b0, 2'd2);
    pulse(1'b0, 2'd1);
    pulse(1'b0, 2'd0);
    pulse(1'b0, 2'd0);
    pulse(1'b0, 2'd0);
  endtask

  task automatic test_simultaneous;
    int n;
    wait_transition("simul_sync");
    run_interval(19, 19, n);
    vectors++;
    if (n !== 113 || octave !== 2'd0) begin
      miscompares++;
      $display("FAIL simultaneous: interval=%0d octave=%0d, expected 113 and 0", n, octave);
    end
  endtask

  task automatic test_handshake;
    logic [3:0] pattern;
    pattern = 4'b1001;
    for (int i = 3; i >= 0; i--) begin
      audio_out_allowed = pattern[i];
      #1;
      vectors++;
      if (write_audio_out !== pattern[i] || left !== right ||
          (pattern[i] && left !== AMP_P && left !== AMP_N)) begin
        miscompares++;
        $display("FAIL handshake[%0d]: write=%0b left=%0d right=%0d, expected write=%0b, equal +/-AMP",
                 i, write_audio_out, $signed(left), $signed(right), pattern[i]);
      end
      tick(1);
    end
    audio_out_allowed = 1'b1;
  endtask

  task automatic test_midrun_reset;
    int n;
    pulse(1'b1, 2'd1);
    n = 0;
    while (left !== AMP_N && n < 300) begin
      tick(1);
      n++;
    end
    tick(20);
    reset = 1'b1;
    tick(1);
    vectors++;
    if (left !== 32'd0 || right !== 32'd0 || octave !== 2'd0 || write_audio_out !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_reset: left=%0d right=%0d octave=%0d write=%0b, expected 0/0/0/0",
               left, right, octave, write_audio_out);
    end
    reset = 1'b0;
    for (int k = 1; k <= 114; k++) begin
      tick(1);
      if (k == 2 || k == 3 || k == 113 || k == 114) begin
        vectors++;
        if (left !== ((k == 2) ? 32'd0 : (k == 114) ? AMP_N : AMP_P)) begin
          miscompares++;
          $display("FAIL restart[%0d]: output=%0d, expected %0d", k, $signed(left),
                   (k == 2) ? 0 : (k == 114) ? -100000000 : 100000000);
        end
      end
    end
  endtask

  task automatic test_saturation;
    vectors++;
    if (s_left !== 32'd0) begin
      miscompares++;
      $display("FAIL sat_reset: output=%h, expected 00000000", s_left);
    end
    s_reset = 1'b0;
    tick(3);
    vectors++;
    if (s_left !== 32'h7FFF_FFFF || s_right !== 32'h7FFF_FFFF) begin
      miscompares++;
      $display("FAIL sat_pos: left=%h right=%h, expected 7fffffff", s_left, s_right);
    end
    tick(57);
    vectors++;
    if (s_left !== 32'h8000_0000 || s_right !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL sat_neg: left=%h right=%h, expected 80000000", s_left, s_right);
    end
  endtask

  initial begin
    reset = 1'b1; keys = '0; oct_up = 1'b0; oct_down = 1'b0; audio_out_allowed = 1'b0;
    s_reset = 1'b1; s_keys = 3'b111; s_up = 1'b0; s_dn = 1'b0; s_allowed = 1'b1;
    test_reset();
    test_single_voice();
    test_octave_up();
    test_simultaneous();
    test_handshake();
    test_midrun_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
